// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, legal oversampling ratios,
// parity-type encodings (also used by the TX parity calculator) and a vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned PRESCALE_8  = 32'd8;
  localparam int unsigned PRESCALE_16 = 32'd16;
  localparam int unsigned PRESCALE_32 = 32'd32;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  function automatic logic majority3(input logic [2:0] smp);
    return (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and a 3-sample
// majority vote taken around the middle of every bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  active_i,
  input  logic                  rx_in_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  sampled_bit_o,
  output logic                  bit_done_o,
  output logic                  sample_valid_o,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]            smp_q, smp_d;
  logic [PRESCALE_W-1:0] half_s;
  logic [PRESCALE_W-1:0] last_s;
  logic                  bit_done_s;

  // Counter and sample-register next state.
  always_comb begin
    half_s     = {1'b0, prescale_i[PRESCALE_W-1:1]};
    last_s     = prescale_i - PRESCALE_W'(1);
    bit_done_s = active_i && (edge_cnt_q == last_s);
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;

    // The IDLE cycle that sees the falling edge is edge 0, so the count resumes at 1.
    if (start_i) begin
      edge_cnt_d = PRESCALE_W'(1);
      bit_cnt_d  = BIT_CNT_W'(0);
    end else if (active_i) begin
      if (bit_done_s) begin
        edge_cnt_d = PRESCALE_W'(0);
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end else begin
      edge_cnt_d = PRESCALE_W'(0);
      bit_cnt_d  = BIT_CNT_W'(0);
    end

    if (active_i) begin
      if (edge_cnt_q == half_s - PRESCALE_W'(1)) begin
        smp_d[0] = rx_in_i;
      end else if (edge_cnt_q == half_s) begin
        smp_d[1] = rx_in_i;
      end else if (edge_cnt_q == half_s + PRESCALE_W'(1)) begin
        smp_d[2] = rx_in_i;
      end else begin
        smp_d = smp_q;
      end
    end else begin
      smp_d = smp_q;
    end
  end

  // Counter and sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= PRESCALE_W'(0);
      bit_cnt_q  <= BIT_CNT_W'(0);
      smp_q      <= 3'b000;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign sampled_bit_o  = majority3(smp_q);
  assign bit_done_o     = bit_done_s;
  assign sample_valid_o = active_i && (edge_cnt_q >= half_s + PRESCALE_W'(2));
  assign bit_cnt_o      = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialization, optional parity
// and stop checking, and registered one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  par_typ_e              par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stop_bad_q, stop_bad_d;
  logic                  resolve_q, resolve_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic                  start_s;
  logic                  active_s;
  logic                  bit_evt_s;
  logic                  sampled_bit_s;
  logic                  bit_done_s;
  logic                  sample_valid_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_s;
  logic [PRESCALE_W-1:0] presc_sel_s;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_sampler (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_s),
    .active_i       (active_s),
    .rx_in_i        (rx_in),
    .prescale_i     (presc_q),
    .sampled_bit_o  (sampled_bit_s),
    .bit_done_o     (bit_done_s),
    .sample_valid_o (sample_valid_s),
    .bit_cnt_o      (bit_cnt_s)
  );

  assign active_s  = (state_q != ST_IDLE);
  assign bit_evt_s = bit_done_s & sample_valid_s;

  // Map unsupported oversampling ratios onto 8.
  always_comb begin
    case (prescale)
      PRESCALE_W'(PRESCALE_8),
      PRESCALE_W'(PRESCALE_16),
      PRESCALE_W'(PRESCALE_32): presc_sel_s = prescale;
      default:                  presc_sel_s = PRESCALE_W'(PRESCALE_8);
    endcase
  end

  // Frame FSM next state plus resolution of the frame that ended last cycle.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    shift_d    = shift_q;
    par_fail_d = par_fail_q;
    stop_bad_d = stop_bad_q;
    resolve_d  = 1'b0;
    start_s    = 1'b0;

    // Resolution runs in IDLE and may overlap the next start detection.
    data_valid_d = resolve_q & ~stop_bad_q & ~par_fail_q;
    par_err_d    = resolve_q & par_fail_q;
    stp_err_d    = resolve_q & stop_bad_q;
    p_data_d     = data_valid_d ? shift_q : p_data_q;

    case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          start_s    = 1'b1;
          state_d    = ST_START;
          presc_d    = presc_sel_s;
          par_en_d   = par_en;
          par_typ_d  = par_typ_e'(par_typ);
          par_fail_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_evt_s) begin
          state_d = sampled_bit_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_evt_s) begin
          shift_d = {sampled_bit_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_s == BIT_CNT_W'(DATA_WIDTH)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_evt_s) begin
          par_fail_d = (sampled_bit_s != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
          state_d    = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_evt_s) begin
          stop_bad_d = ~sampled_bit_s;
          resolve_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured frame configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= PRESCALE_W'(PRESCALE_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      shift_q      <= '0;
      par_fail_q   <= 1'b0;
      stop_bad_q   <= 1'b0;
      resolve_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      par_fail_q   <= par_fail_d;
      stop_bad_q   <= stop_bad_d;
      resolve_q    <= resolve_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
